// File: rtl/pipe_pkg.sv
// Shared pipeline types for the forwarding / hazard logic.
package pipe_pkg;

    localparam int unsigned REG_AW_DEFAULT = 5;
    // Widest bypass select any instance may request from onehot_rf().
    localparam int unsigned SEL_W_MAX      = 16;

    // Destination tag carried down the shadow pipeline.
    typedef struct packed {
        logic                      valid;
        logic [REG_AW_DEFAULT-1:0] rd;
        logic                      rw;
        logic                      mr;
    } dest_tag_t;

    localparam int unsigned TAG_W = $bits(dest_tag_t);

    // Bypass select that picks the register file (bit0); callers truncate to width.
    function automatic logic [SEL_W_MAX-1:0] onehot_rf();
        return SEL_W_MAX'(1);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Priority matcher: one-hot bypass select for one EX source operand.
// The nearest qualifying stage wins; with no match the register file is selected.
module fwd_select
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW     = REG_AW_DEFAULT,
    parameter int unsigned FWD_STAGES = 2,
    parameter int unsigned LOAD_LAT   = 1
) (
    input  logic                    ex_valid,
    input  logic [REG_AW-1:0]       src,
    input  dest_tag_t [FWD_STAGES:1] stg,
    output logic [FWD_STAGES:0]     sel
);

    localparam int unsigned SEL_W = FWD_STAGES + 1;

    logic [SEL_W-1:0] qual;
    logic [SEL_W-1:0] lowest;

    assign qual[0] = 1'b0;

    // Per-stage candidate: live writer of a non-zero rd matching src, load data ready.
    for (genvar k = 1; k <= FWD_STAGES; k++) begin : g_qual
        localparam bit LOAD_READY = (k >= LOAD_LAT + 1);
        assign qual[k] = ex_valid
                       && stg[k].valid
                       && stg[k].rw
                       && (stg[k].rd != '0)
                       && (stg[k].rd == REG_AW_DEFAULT'(src))
                       && (!stg[k].mr || LOAD_READY);
    end

    // Isolate the lowest set bit, i.e. the youngest producer.
    assign lowest = qual & (~qual + SEL_W'(1));

    // Fall back to the register file when nothing qualifies.
    always_comb begin
        sel = SEL_W'(onehot_rf());
        if (qual != '0) begin
            sel = lowest;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the in-order pipeline.
// Tracks in-flight destination tags for EX plus FWD_STAGES post-EX stages,
// produces one-hot EX operand bypass selects and the ID load-use stall.
// REG_AW must not exceed pipe_pkg::REG_AW_DEFAULT (tag width).
// Optional: define FWD_HAZARD_STATS_EN to add saturating stall/forward counters.
module fwd_hazard_unit
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW     = REG_AW_DEFAULT,
    parameter int unsigned FWD_STAGES = 2,
    parameter int unsigned LOAD_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_AW-1:0]     id_rs,
    input  logic [REG_AW-1:0]     id_rt,
    input  logic [REG_AW-1:0]     id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic                  stall,
    output logic [FWD_STAGES:0]   fwd_a,
    output logic [FWD_STAGES:0]   fwd_b
`ifdef FWD_HAZARD_STATS_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           fwd_events
`endif
);

    localparam int unsigned STG_BITS = FWD_STAGES * TAG_W;

    dest_tag_t                 ex_tag;
    logic [REG_AW-1:0]         ex_rs;
    logic [REG_AW-1:0]         ex_rt;
    dest_tag_t [FWD_STAGES:1]  stg;
    dest_tag_t [FWD_STAGES:0]  all_tags;
    logic                      issue;
    logic [FWD_STAGES:0]       hit_rs;
    logic [FWD_STAGES:0]       hit_rt;

    assign issue = id_valid && !stall && !flush;

    // EX entry capture and shadow shift; the oldest stage falls off the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_tag <= '0;
            ex_rs  <= '0;
            ex_rt  <= '0;
            stg    <= '0;
        end else begin
            stg       <= STG_BITS'({stg, ex_tag});
            ex_tag.valid <= issue;
            ex_tag.rd    <= REG_AW_DEFAULT'(id_rd);
            ex_tag.rw    <= id_reg_write;
            ex_tag.mr    <= id_mem_read;
            ex_rs     <= id_rs;
            ex_rt     <= id_rt;
        end
    end

    // Position 0 is EX, position k is post-EX stage k.
    assign all_tags = {stg, ex_tag};

    // A load at position j is not yet forwardable to the next EX while j < LOAD_LAT.
    for (genvar j = 0; j <= FWD_STAGES; j++) begin : g_hit
        if (j < LOAD_LAT) begin : g_pending
            assign hit_rs[j] = all_tags[j].valid && all_tags[j].rw && all_tags[j].mr
                             && (all_tags[j].rd != '0)
                             && (all_tags[j].rd == REG_AW_DEFAULT'(id_rs));
            assign hit_rt[j] = all_tags[j].valid && all_tags[j].rw && all_tags[j].mr
                             && (all_tags[j].rd != '0)
                             && (all_tags[j].rd == REG_AW_DEFAULT'(id_rt));
        end else begin : g_ready
            assign hit_rs[j] = 1'b0;
            assign hit_rt[j] = 1'b0;
        end
    end

    assign stall = id_valid && !flush && ((|hit_rs) || (|hit_rt));

    fwd_select #(
        .REG_AW     (REG_AW),
        .FWD_STAGES (FWD_STAGES),
        .LOAD_LAT   (LOAD_LAT)
    ) u_sel_a (
        .ex_valid (ex_tag.valid),
        .src      (ex_rs),
        .stg      (stg),
        .sel      (fwd_a)
    );

    fwd_select #(
        .REG_AW     (REG_AW),
        .FWD_STAGES (FWD_STAGES),
        .LOAD_LAT   (LOAD_LAT)
    ) u_sel_b (
        .ex_valid (ex_tag.valid),
        .src      (ex_rt),
        .stg      (stg),
        .sel      (fwd_b)
    );

`ifdef FWD_HAZARD_STATS_EN
    logic [1:0]  fwd_inc;
    logic [32:0] fwd_sum;

    assign fwd_inc = 2'(ex_tag.valid && !fwd_a[0]) + 2'(ex_tag.valid && !fwd_b[0]);
    assign fwd_sum = {1'b0, fwd_events} + 33'(fwd_inc);

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            fwd_events   <= '0;
        end else begin
            if (stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            fwd_events <= fwd_sum[32] ? '1 : fwd_sum[31:0];
        end
    end
`endif

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parametrised forwarding and load-use hazard unit for the in-order pipeline. It keeps a shadow shift register of in-flight destination tags, covering EX plus FWD_STAGES post-EX stages. From that state it derives one-hot operand bypass selects for the instruction in EX, and a stall for the instruction in ID. It sits beside the ID/EX boundary, is fed from decode, and drives the EX operand muxes and the IF/ID hold and bubble logic.

Parameters:
REG_AW, 5, register address width; register 0 is hard-wired zero and never forwarded.
FWD_STAGES, 2, number of post-EX pipeline registers that can forward. Stage 1 is nearest (EX/MEM).
LOAD_LAT, 1, load result first forwardable from stage LOAD_LAT+1. Legal range 0 to FWD_STAGES-1.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rs  in  REG_AW  ID source A
id_rt  in  REG_AW  ID source B
id_rd  in  REG_AW  ID destination
id_reg_write  in  1  ID instruction writes rd
id_mem_read  in  1  ID instruction is a load
flush  in  1  kill ID instruction (branch taken); it issues as a bubble
stall  out  1  hold PC and IF/ID; insert bubble into EX
fwd_a  out  FWD_STAGES+1  one-hot select for operand A. Bit0 is the register file; bit k is stage k.
fwd_b  out  FWD_STAGES+1  one-hot select for operand B, same encoding as fwd_a

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset clears all shadow valid bits and the EX entry. Outputs go to stall=0, fwd_a=fwd_b=one-hot bit0.
- State:
  - EX entry: valid, rs, rt, rd, rw, mr.
  - Shadow stages s[1..FWD_STAGES]: valid, rd, rw, mr.
- Every clock edge:
  - s[k+1] <= s[k] and s[1] <= EX entry. The oldest stage drops out; the register file then holds its value (write-before-read).
  - EX entry <= ID fields, valid = id_valid & ~stall & ~flush. A stall or flush loads a bubble with valid=0.
- Forwarding is combinational from registered state only; there are no input-to-output paths for fwd_*.
  - Candidate stage k for operand A requires: s[k].valid & s[k].rw & s[k].rd!=0 & s[k].rd==ex.rs & (~s[k].mr | k>=LOAD_LAT+1).
  - The lowest qualifying k wins (youngest producer). With no candidate, select bit0.
  - Operand B is identical using ex.rt.
  - An invalid EX entry drives bit0 on both operands.
  - Exactly one bit is high at all times.
- Load-use stall is combinational. stall = id_valid & ~flush & (hit_rs | hit_rt), where for source s:
  - EX entry valid & rw & mr & rd!=0 & rd==s, or
  - any s[k] with k<LOAD_LAT, valid & rw & mr & rd!=0 & rd==s.
- With LOAD_LAT=0 loads forward from stage 1 and stall is constantly 0.
- The stall count per dependent instruction is LOAD_LAT+1-d cycles, where d is the producer distance. This is self-timed by the shadow shift; no extra counter is needed.
- flush and stall together: flush wins, stall=0, bubble inserted.
- Reset mid-stall: stall drops asynchronously, since all state is cleared.
- A non-writing instruction with rd matching a source never forwards.

Optional Feature:
- Macro FWD_HAZARD_STATS_EN.
- When defined, adds output ports stall_cycles[31:0] and fwd_events[31:0], both reset to 0.
  - stall_cycles increments each cycle stall=1.
  - fwd_events increments by the number of operands (0, 1 or 2) whose select is not bit0 while the EX entry is valid.
  - Both counters saturate at all-ones.
- When undefined, neither the ports nor the counters exist. Core behaviour is identical either way.

Decomposition:
- Shared package pipe_pkg holds:
  - REG_AW_DEFAULT;
  - typedef dest_tag_t struct {valid, rd, rw, mr};
  - function onehot_rf(), returning the bit0 select.
- One sub-module, fwd_select: a combinational priority matcher over the stage array that returns a one-hot select. It is instantiated twice, for rs and rt.

Test Plan:
- Defaults. ADD r3 then ADD using r3 as rs -> fwd_a=010 in the consumer's EX cycle, fwd_b=001.
- Producer r3, one unrelated instruction, consumer reads r3 as rt -> fwd_b=100. With producers to r3 at both stages, fwd_b=010 (youngest wins).
- LW r4 then ADD using r4 -> stall=1 for exactly 1 cycle and bubble in EX; next cycle fwd_a=100.
- LOAD_LAT=2, FWD_STAGES=3: LW r5 then immediate consumer -> 2 stall cycles, then fwd=1000.
- Writes to r0 followed by a reader of r0 -> fwd=001 and no stall. Load-use with flush=1 in the same cycle -> stall=0.
- Reset asserted mid-stall -> stall and fwd return to 0/001 immediately. With FWD_HAZARD_STATS_EN, stall_cycles resets to 0 and the earlier load-use case counts 1.
